// File: rtl/sop_scheduler.sv
// sop_scheduler
// Sequences the 7x7 fixed-point sum-of-products unit over one output
// feature map per start. Each accepted window launches one SOP; the result
// is awaited with a timeout, tagged with its (row, col) and parked in a
// one-entry valid/ready output register for the feature-map writer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame running; start begins a frame at (0,0)
// S_ISSUE | offering win_ready; a window handshake launches one SOP
// S_WAIT  | SOP in flight; timer counts cycles since the enable pulse
// S_DONE  | last result issued; waits for it to drain, pulses frame_done
// S_ERR   | SOP timed out; err_timeout held until the next start
//
// Ports:
//   ap_clk, ap_rst_n      clock, synchronous active-low reset
//   start                 frame start pulse (honoured in IDLE / ERR)
//   busy, frame_done      frame status
//   err_timeout           sticky SOP timeout flag
//   win_valid, win_ready  window handshake from the window generator
//   sop_enable            registered one-cycle launch pulse to fp_sop
//   sop_out_valid/_val    fp_sop result
//   res_valid/res_ready   output register handshake
//   res_data/row/col      tagged result
module sop_scheduler #(
    parameter int OUT_W   = 26,
    parameter int OUT_H   = 26,
    parameter int DATA_W  = 16,
    parameter int COORD_W = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    output logic               err_timeout,
    input  logic               win_valid,
    output logic               win_ready,
    output logic               sop_enable,
    input  logic               sop_out_valid,
    input  logic [DATA_W-1:0]  sop_out_val,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [COORD_W-1:0] res_row,
    output logic [COORD_W-1:0] res_col
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [COORD_W-1:0] row_cnt;
    logic [COORD_W-1:0] col_cnt;

    logic launch;
    logic accept;
    logic drain;
    logic last_coord;
    logic col_wrap;

    // Launch is held off while the output register is full and not draining,
    // so a result can never overwrite an unconsumed one.
    assign win_ready  = (state == S_ISSUE) && (!res_valid || res_ready);
    assign launch     = win_valid && win_ready;
    assign drain      = res_valid && res_ready;
    // timer == 0 marks the enable cycle itself, where a result is not yet legal.
    assign accept     = (state == S_WAIT) && (timer != '0) && sop_out_valid;
    assign col_wrap   = (col_cnt == COORD_W'(OUT_W - 1));
    assign last_coord = col_wrap && (row_cnt == COORD_W'(OUT_H - 1));
    assign busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            sop_enable  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_row     <= '0;
            res_col     <= '0;
        end else begin
            sop_enable <= 1'b0;
            frame_done <= 1'b0;

            // Output register: a load wins over a drain in the same cycle.
            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= sop_out_val;
                res_row   <= row_cnt;
                res_col   <= col_cnt;
            end else if (drain) begin
                res_valid <= 1'b0;
            end

            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        row_cnt     <= '0;
                        col_cnt     <= '0;
                        err_timeout <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (launch) begin
                        sop_enable <= 1'b1;
                        timer      <= '0;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (accept) begin
                        if (col_wrap) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + COORD_W'(1);
                        end else begin
                            col_cnt <= col_cnt + COORD_W'(1);
                        end
                        state <= last_coord ? S_DONE : S_ISSUE;
                    end else if (timer == TMR_W'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_DONE: begin
                    // frame_done is raised while still in DONE so that it
                    // and busy drop on the same edge.
                    if (frame_done) begin
                        state <= S_IDLE;
                    end else if (!res_valid) begin
                        frame_done <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sop_scheduler.sv
module tb_sop_scheduler;

    localparam int OUT_W   = 2;
    localparam int OUT_H   = 2;
    localparam int DATA_W  = 16;
    localparam int COORD_W = 8;
    localparam int TIMEOUT = 64;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               frame_done;
    logic               err_timeout;
    logic               win_valid = 1'b0;
    logic               win_ready;
    logic               sop_enable;
    logic               sop_out_valid = 1'b0;
    logic [DATA_W-1:0]  sop_out_val = '0;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [DATA_W-1:0]  res_data;
    logic [COORD_W-1:0] res_row;
    logic [COORD_W-1:0] res_col;

    int n_vec  = 0;
    int n_fail = 0;

    sop_scheduler #(
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .DATA_W (DATA_W),
        .COORD_W(COORD_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .sop_enable   (sop_enable),
        .sop_out_valid(sop_out_valid),
        .sop_out_val  (sop_out_val),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_row      (res_row),
        .res_col      (res_col)
    );

    always #5 ap_clk = ~ap_clk;

    // SOP model: result 6223*k (k = enable count) appears model_lat cycles
    // after the enable cycle; model_lat = 0 means it never answers.
    int          model_lat = 3;
    int          model_k   = 0;
    int          pend      = 0;
    logic [15:0] pend_val  = '0;

    always @(negedge ap_clk) begin
        sop_out_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                sop_out_valid = 1'b1;
                sop_out_val   = pend_val;
            end
        end
        if (sop_enable === 1'b1) begin
            pend     = model_lat;
            pend_val = 16'(6223 * model_k);
            model_k++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", err_timeout, 0);
    endtask

    // Leaves the bench in cycle e+1 (one after the enable cycle).
    task automatic do_launch(input int lat);
        model_lat = lat;
        win_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (win_ready === 1'b1) break;
            tick();
        end
        check("win_ready_wait", win_ready, 1);
        tick();
        win_valid = 1'b0;
        check("sop_enable_on", sop_enable, 1);
        tick();
        check("sop_enable_pulse", sop_enable, 0);
    endtask

    // Called in cycle e+1+already; result must appear exactly at e+lat+1.
    task automatic expect_result(input int lat, input logic [7:0] row, input logic [7:0] col,
                                 input logic [15:0] data, input int already);
        repeat (lat - 1 - already) tick();
        check("res_not_early", res_valid, 0);
        tick();
        check("res_valid", res_valid, 1);
        check("res_row", res_row, row);
        check("res_col", res_col, col);
        check("res_data", res_data, data);
        check("res_err", err_timeout, 0);
    endtask

    task automatic expect_timeout();
        repeat (TIMEOUT - 1) tick();
        check("err_before_expiry", err_timeout, 0);
        tick();
        check("err_timeout", err_timeout, 1);
        check("err_busy", busy, 0);
        check("err_res_valid", res_valid, 0);
    endtask

    task automatic expect_frame_done();
        for (int i = 0; i < 10; i++) begin
            if (frame_done === 1'b1) break;
            tick();
        end
        check("frame_done", frame_done, 1);
        check("frame_done_busy", busy, 1);
        tick();
        check("frame_done_pulse", frame_done, 0);
        check("frame_done_busy_fall", busy, 0);
    endtask

    typedef struct {
        int          lat;
        bit          exp_err;
        bit          exp_done;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] data;
    } vec_t;

    vec_t vt[12];

    initial begin
        // lat, err, done, row, col, data (data = 6223*vector index mod 2^16)
        vt[0]  = '{3,  1'b0, 1'b0, 8'd0, 8'd0, 16'd0};
        vt[1]  = '{3,  1'b0, 1'b0, 8'd0, 8'd1, 16'd6223};
        vt[2]  = '{3,  1'b0, 1'b0, 8'd1, 8'd0, 16'd12446};
        vt[3]  = '{3,  1'b0, 1'b1, 8'd1, 8'd1, 16'd18669};
        vt[4]  = '{64, 1'b0, 1'b0, 8'd0, 8'd0, 16'd24892};
        vt[5]  = '{65, 1'b1, 1'b0, 8'd0, 8'd0, 16'd0};
        vt[6]  = '{1,  1'b0, 1'b0, 8'd0, 8'd0, 16'd37338};
        vt[7]  = '{0,  1'b1, 1'b0, 8'd0, 8'd0, 16'd0};
        vt[8]  = '{2,  1'b0, 1'b0, 8'd0, 8'd0, 16'd49784};
        vt[9]  = '{3,  1'b0, 1'b0, 8'd0, 8'd1, 16'd56007};
        vt[10] = '{64, 1'b0, 1'b0, 8'd1, 8'd0, 16'd62230};
        vt[11] = '{3,  1'b0, 1'b1, 8'd1, 8'd1, 16'd2917};

        // Reset held with start and win_valid asserted.
        ap_rst_n  = 1'b0;
        start     = 1'b1;
        win_valid = 1'b1;
        repeat (5) tick();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_win_ready", win_ready, 0);
        check("rst_sop_enable", sop_enable, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_row", res_row, 0);
        check("rst_res_col", res_col, 0);
        start     = 1'b0;
        win_valid = 1'b0;
        ap_rst_n  = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_sop_enable", sop_enable, 0);

        // Frames, timeout boundaries and error recovery.
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b1) do_start();
            do_launch(vt[i].lat);
            if (vt[i].exp_err) expect_timeout();
            else expect_result(vt[i].lat, vt[i].row, vt[i].col, vt[i].data, 0);
            if (vt[i].exp_done) expect_frame_done();
        end

        // Backpressure on the first result of a frame (k = 12, 13).
        do_start();
        res_ready = 1'b0;
        do_launch(3);
        expect_result(3, 8'd0, 8'd0, 16'd9140, 0);
        model_lat = 3;
        win_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, 16'd9140);
            check("bp_res_row", res_row, 0);
            check("bp_res_col", res_col, 0);
            check("bp_win_ready", win_ready, 0);
            check("bp_sop_enable", sop_enable, 0);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_win_ready", win_ready, 1);
        tick();
        win_valid = 1'b0;
        check("bp_launch_enable", sop_enable, 1);
        check("bp_drained", res_valid, 0);
        tick();
        check("bp_enable_pulse", sop_enable, 0);
        expect_result(3, 8'd0, 8'd1, 16'd15363, 0);

        // start ignored mid-frame, in ISSUE and in WAIT (k = 14).
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_start_busy", busy, 1);
        do_launch(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_result(5, 8'd1, 8'd0, 16'd21586, 1);

        // Reset while waiting; the late result must be dropped (k = 15).
        do_launch(10);
        tick();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("wait_rst_busy", busy, 0);
        check("wait_rst_res_valid", res_valid, 0);
        check("wait_rst_sop_enable", sop_enable, 0);
        check("wait_rst_win_ready", win_ready, 0);
        repeat (8) tick();
        check("late_valid_res", res_valid, 0);
        check("late_valid_busy", busy, 0);
        check("late_valid_err", err_timeout, 0);

        // Clean restart at (0,0) (k = 16).
        do_start();
        do_launch(3);
        expect_result(3, 8'd0, 8'd0, 16'd34032, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sop_scheduler.md
Name: sop_scheduler

Overview:
Sequencer for the 7x7 fixed-point sum-of-products unit (fp_sop). It accepts window-ready handshakes from the window generator and issues one-cycle sop_enable pulses. It waits for the SOP result with a timeout, tags each result with its output feature-map (row, col) coordinate, and forwards it downstream through a one-entry valid/ready output register. It sits between the line-buffer/window generator and the feature-map writer, and runs one OUT_H x OUT_W frame per start.

Parameters:
OUT_W, 26, output feature-map width (columns per row), >=1
OUT_H, 26, output feature-map height (rows per frame), >=1
DATA_W, 16, SOP result width
COORD_W, 8, width of row/col coordinate outputs; must hold max(OUT_W,OUT_H)-1
TIMEOUT, 64, max cycles to wait for sop_out_valid after sop_enable, >=2

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle pulse; begins a frame from IDLE or ERR
busy  out  1  high in ISSUE, WAIT, DONE
frame_done  out  1  one-cycle pulse when the last result of a frame has drained
err_timeout  out  1  sticky timeout flag; cleared by start or reset
win_valid  in  1  window generator has a 7x7 window ready
win_ready  out  1  scheduler accepts the window (SOP launch)
sop_enable  out  1  one-cycle start pulse to fp_sop, registered
sop_out_valid  in  1  fp_sop result valid
sop_out_val  in  DATA_W  fp_sop result
res_valid  out  1  output register holds a result
res_ready  in  1  downstream accepts the result
res_data  out  DATA_W  result value
res_row  out  COORD_W  row of the result
res_col  out  COORD_W  column of the result

Behaviour:
- Reset (ap_rst_n=0 at a rising edge): state IDLE; row/col counters, timer, and all outputs 0. Reset mid-frame aborts the frame and discards any pending result.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: busy=0. start -> clear counters and err_timeout, go to ISSUE.
- ISSUE: win_ready = !res_valid || res_ready (combinational, ISSUE only). On win_valid && win_ready at cycle t, sop_enable=1 during cycle t+1 only, go to WAIT, timer=0.
- WAIT: win_ready=0. The timer increments each cycle after the sop_enable cycle e. sop_out_valid is accepted in cycles e+1 .. e+TIMEOUT.
  - On acceptance at cycle u: at u+1, res_data=sop_out_val unmodified, res_row/res_col=current counters, and res_valid=1.
  - The counters then advance: col wraps OUT_W-1 -> 0 and increments row.
  - If the coordinate was (OUT_H-1, OUT_W-1), go to DONE; otherwise go to ISSUE.
  - If no valid arrives by e+TIMEOUT: err_timeout=1 at e+TIMEOUT+1, go to ERR.
  - Valid arriving in the expiry cycle is accepted; there is no error.
- sop_out_valid outside WAIT, or at cycle e itself, is ignored.
- Output register: holds res_* stable while res_valid && !res_ready. It clears on res_valid && res_ready unless reloaded in the same cycle. It is never overwritten while full, because ISSUE gates launch on it.
- DONE: busy=1. Once res_valid=0, frame_done pulses for one cycle and the state goes to IDLE. frame_done and busy fall together.
- ERR: busy=0, sop_enable=0, win_ready=0. Any buffered result still drains. start -> clears err_timeout and restarts at (0,0).
- start in ISSUE/WAIT/DONE is ignored.
- Throughput: at most one SOP in flight. The next win_ready is at the earliest u+1.

Test Plan:
1. Reset with ap_rst_n=0 and start=1 held for 5 cycles -> all outputs 0, busy=0, and start has no effect until reset releases.
2. OUT_W=2, OUT_H=2; SOP model returns 6223*k three cycles after the enable; res_ready=1; win_valid=1 -> exactly 4 single-cycle sop_enable pulses; results (0,0),(0,1),(1,0),(1,1) with values 0,6223,12446,18669; one frame_done pulse after the 4th result drains.
3. Backpressure: res_ready=0 for 10 cycles after the first result -> res_data/row/col stable, win_ready=0, no sop_enable; on release, the next launch occurs in the cycle of acceptance.
4. Timeout: SOP model never asserts valid, TIMEOUT=64 -> err_timeout=1 exactly 65 cycles after the sop_enable cycle, busy=0. Then start -> err_timeout=0 and the next result is tagged (0,0).
5. Timeout boundary: valid arrives at e+TIMEOUT -> accepted, err_timeout stays 0. Valid arriving at e+TIMEOUT+1 -> ignored, err_timeout=1.
6. start pulsed mid-frame -> ignored, counters continue. ap_rst_n=0 while in WAIT -> IDLE next cycle with res_valid=0, and a late sop_out_valid is ignored.
